fmc516_spi3w_slave: RTL and testbench



---
 rtl/fmc516_spi3w_slave.sv | 144 ++++++++++++++
 tb/tb_fmc516_spi3w_slave.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fmc516_spi3w_slave.sv
// 3-wire SPI responder for the FMC516 sys_spi bus: oversampled pins, 16-bit header,
// byte-wide register file with streaming auto-increment for both reads and writes.
module fmc516_spi3w_slave #(
  parameter int         g_addr_width = 5,
  parameter logic [7:0] g_chip_id    = 8'hA5
) (
  input  logic                    sys_clk_i,
  input  logic                    sys_rst_i,
  input  logic                    spi_clk_i,
  input  logic                    spi_cs_n_i,
  input  logic                    spi_sdio_i,
  output logic                    spi_sdio_o,
  output logic                    spi_sdio_oe_o,
  output logic                    reg_wr_o,
  output logic [g_addr_width-1:0] reg_addr_o,
  output logic [7:0]              reg_wdata_o,
  output logic                    busy_o
);

  localparam int DEPTH = 2**g_addr_width;

  typedef enum logic [1:0] {IDLE, HEADER, WR_DATA, RD_DATA} state_t;

  // [0],[1] synchronizer, [2] edge-detect history. Reset to 0 so an already-low
  // cs_n after reset never looks like a fall.
  logic [2:0] sclk_sr, csn_sr;
  logic [1:0] sdio_sr;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      sclk_sr <= '0;
      csn_sr  <= '0;
      sdio_sr <= '0;
    end else begin
      sclk_sr <= {sclk_sr[1:0], spi_clk_i};
      csn_sr  <= {csn_sr[1:0], spi_cs_n_i};
      sdio_sr <= {sdio_sr[0], spi_sdio_i};
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, sdio_s;
  assign sclk_rise = sclk_sr[1] & ~sclk_sr[2];
  assign sclk_fall = ~sclk_sr[1] & sclk_sr[2];
  assign cs_fall   = ~csn_sr[1] & csn_sr[2];
  assign cs_rise   = csn_sr[1] & ~csn_sr[2];
  assign sdio_s    = sdio_sr[1];

  state_t                  state;
  logic [3:0]              bit_cnt;
  logic [14:0]             sh;
  logic [7:0]              rd_sh;
  logic [g_addr_width-1:0] addr;
  logic [7:0]              mem [DEPTH];

  logic [g_addr_width-1:0] hdr_addr, addr_inc;
  logic [7:0]              wr_byte;
  assign hdr_addr = {sh[g_addr_width-2:0], sdio_s};
  assign addr_inc = addr + 1'b1;
  assign wr_byte  = {sh[6:0], sdio_s};

  function automatic logic [7:0] rd_val(input logic [g_addr_width-1:0] a);
    return (a == '0) ? g_chip_id : mem[a];
  endfunction

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      sh            <= '0;
      rd_sh         <= '0;
      addr          <= '0;
      spi_sdio_o    <= 1'b0;
      spi_sdio_oe_o <= 1'b0;
      reg_wr_o      <= 1'b0;
      reg_addr_o    <= '0;
      reg_wdata_o   <= '0;
      busy_o        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      reg_wr_o <= 1'b0;
      if (cs_rise) begin
        // Deselect wins over any coincident SCLK event; partial bits are dropped.
        state         <= IDLE;
        bit_cnt       <= '0;
        spi_sdio_oe_o <= 1'b0;
        spi_sdio_o    <= 1'b0;
        busy_o        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            if (cs_fall) begin
              state  <= HEADER;
              busy_o <= 1'b1;
            end
          end
          HEADER: if (sclk_rise) begin
            sh      <= {sh[13:0], sdio_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              bit_cnt <= '0;
              addr    <= hdr_addr;
              if (sh[14]) begin
                state <= RD_DATA;
                rd_sh <= rd_val(hdr_addr);
              end else begin
                state <= WR_DATA;
              end
            end
          end
          WR_DATA: if (sclk_rise) begin
            sh      <= {sh[13:0], sdio_s};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              addr    <= addr_inc;
              if (addr != '0) begin
                mem[addr]   <= wr_byte;
                reg_wr_o    <= 1'b1;
                reg_addr_o  <= addr;
                reg_wdata_o <= wr_byte;
              end
            end
          end
          RD_DATA: if (sclk_fall) begin
            spi_sdio_oe_o <= 1'b1;
            spi_sdio_o    <= rd_sh[7];
            bit_cnt       <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              // Last bit just went out: prefetch the next byte so the stream is gapless.
              bit_cnt <= '0;
              addr    <= addr_inc;
              rd_sh   <= rd_val(addr_inc);
            end else begin
              rd_sh <= {rd_sh[6:0], 1'b0};
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fmc516_spi3w_slave.sv
// Directed bench for fmc516_spi3w_slave: stimulus pushes expected commits and read
// bytes into queues, independent monitors pop and compare as the DUT produces them.
module tb_fmc516_spi3w_slave;

  localparam int AW = 5;
  localparam int H  = 6;  // sys_clk cycles per SCLK half period

  logic          sys_clk_i = 1'b0;
  logic          sys_rst_i;
  logic          spi_clk_i, spi_cs_n_i, spi_sdio_i;
  logic          spi_sdio_o, spi_sdio_oe_o, reg_wr_o, busy_o;
  logic [AW-1:0] reg_addr_o;
  logic [7:0]    reg_wdata_o;

  fmc516_spi3w_slave #(.g_addr_width(AW), .g_chip_id(8'hA5)) dut (
    .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
    .spi_clk_i(spi_clk_i), .spi_cs_n_i(spi_cs_n_i), .spi_sdio_i(spi_sdio_i),
    .spi_sdio_o(spi_sdio_o), .spi_sdio_oe_o(spi_sdio_oe_o),
    .reg_wr_o(reg_wr_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .busy_o(busy_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int ntests = 0;
  int nfail  = 0;

  logic [12:0] exp_wr [$];  // {addr, data}
  logic [7:0]  exp_rd [$];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Commit monitor
  initial forever begin
    @(negedge sys_clk_i);
    if (reg_wr_o) begin
      if (exp_wr.size() == 0) check("unexpected_wr", {3'b0, reg_addr_o, reg_wdata_o}, 16'h0);
      else begin
        logic [12:0] e;
        e = exp_wr.pop_front();
        check("wr_commit", {3'b0, reg_addr_o, reg_wdata_o}, {3'b0, e});
      end
    end
    if (!spi_sdio_oe_o && spi_sdio_o) check("sdio_when_oe_low", 16'(spi_sdio_o), 16'h0);
  end

  // Read-data monitor: the master side samples SDIO on SCLK rise
  initial begin
    logic [7:0] acc;
    int n;
    acc = '0;
    n = 0;
    forever begin
      @(posedge spi_clk_i);
      if (spi_sdio_oe_o) begin
        acc = {acc[6:0], spi_sdio_o};
        n++;
        if (n == 8) begin
          n = 0;
          if (exp_rd.size() == 0) check("unexpected_rd", 16'(acc), 16'h0);
          else begin
            logic [7:0] e;
            e = exp_rd.pop_front();
            check("rd_byte", 16'(acc), 16'(e));
          end
        end
      end else n = 0;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge sys_clk_i);
  endtask

  task automatic clk_bit(input logic b);
    spi_sdio_i = b;
    clks(H);
    spi_clk_i = 1'b1;
    clks(H);
    spi_clk_i = 1'b0;
  endtask

  task automatic spi_hdr(input logic [15:0] h, input bit chk_oe);
    logic [15:0] hv;
    hv = h;
    spi_cs_n_i = 1'b0;
    clks(H);
    for (int i = 15; i >= 1; i--) clk_bit(hv[i]);
    spi_sdio_i = hv[0];
    clks(H);
    spi_clk_i = 1'b1;
    clks(H);
    if (chk_oe) check("oe_before_first_fall", 16'(spi_sdio_oe_o), 16'h0);
    spi_clk_i = 1'b0;
    clks(4);
    if (chk_oe) check("oe_after_first_fall", 16'(spi_sdio_oe_o), 16'h1);
  endtask

  task automatic wr_byte(input logic [7:0] b);
    logic [7:0] bv;
    bv = b;
    for (int i = 7; i >= 0; i--) clk_bit(bv[i]);
  endtask

  task automatic rd_bytes(input int n);
    repeat (n * 8) clk_bit(1'b0);
  endtask

  task automatic cs_up(input int gap);
    clks(H);
    spi_cs_n_i = 1'b1;
    clks(gap);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sys_rst_i  = 1'b1;
    spi_clk_i  = 1'b0;
    spi_cs_n_i = 1'b1;
    spi_sdio_i = 1'b0;
    clks(5);
    check("rst_oe",    16'(spi_sdio_oe_o), 16'h0);
    check("rst_sdio",  16'(spi_sdio_o),    16'h0);
    check("rst_wr",    16'(reg_wr_o),      16'h0);
    check("rst_busy",  16'(busy_o),        16'h0);
    check("rst_addr",  16'(reg_addr_o),    16'h0);
    check("rst_wdata", 16'(reg_wdata_o),   16'h0);
    sys_rst_i = 1'b0;
    clks(5);

    // 1: single write then readback
    exp_wr.push_back({5'd3, 8'h5C});
    spi_hdr(16'h0003, 0); wr_byte(8'h5C); cs_up(3*H);
    exp_rd.push_back(8'h5C);
    spi_hdr(16'h8003, 0); rd_bytes(1); cs_up(3*H);

    // 2: chip id read, output-enable timing around header end and deselect
    exp_rd.push_back(8'hA5);
    spi_hdr(16'h8000, 1); rd_bytes(1);
    clks(H);
    spi_cs_n_i = 1'b1;
    clks(2);
    check("oe_2clk_after_cs_rise", 16'(spi_sdio_oe_o), 16'h1);
    clks(1);
    check("oe_3clk_after_cs_rise", 16'(spi_sdio_oe_o), 16'h0);
    clks(3*H);

    // 3: streaming write across the wrap; address 0 is dropped
    exp_wr.push_back({5'd31, 8'h11});
    exp_wr.push_back({5'd1,  8'h33});
    spi_hdr(16'h001F, 0); wr_byte(8'h11); wr_byte(8'h22); wr_byte(8'h33); cs_up(3*H);
    exp_rd.push_back(8'h11);
    exp_rd.push_back(8'hA5);
    exp_rd.push_back(8'h33);
    spi_hdr(16'h801F, 0); rd_bytes(3); cs_up(3*H);

    // 4: aborted write after 5 data bits
    spi_hdr(16'h0004, 0);
    for (int i = 0; i < 5; i++) clk_bit(1'b1);
    cs_up(3*H);
    check("abort_busy", 16'(busy_o), 16'h0);
    exp_rd.push_back(8'h00);
    spi_hdr(16'h8004, 0); rd_bytes(1); cs_up(3*H);

    // 5: back-to-back writes with one SCLK period of deselect
    exp_wr.push_back({5'd2, 8'hF0});
    spi_hdr(16'h0002, 0); wr_byte(8'hF0); cs_up(2*H);
    exp_wr.push_back({5'd3, 8'h0F});
    spi_hdr(16'h0003, 0); wr_byte(8'h0F); cs_up(3*H);
    exp_rd.push_back(8'hF0);
    exp_rd.push_back(8'h0F);
    spi_hdr(16'h8002, 0); rd_bytes(2); cs_up(3*H);

    // 6: reset mid read, no resync on a held-low cs_n
    spi_hdr(16'h8000, 0);
    for (int i = 0; i < 4; i++) clk_bit(1'b0);
    sys_rst_i = 1'b1;
    clks(1);
    check("rst_mid_oe",   16'(spi_sdio_oe_o), 16'h0);
    check("rst_mid_busy", 16'(busy_o),        16'h0);
    sys_rst_i = 1'b0;
    for (int i = 0; i < 6; i++) clk_bit(1'b0);
    check("post_rst_oe",   16'(spi_sdio_oe_o), 16'h0);
    check("post_rst_busy", 16'(busy_o),        16'h0);
    cs_up(3*H);
    exp_rd.push_back(8'hA5);
    spi_hdr(16'h8000, 0); rd_bytes(1); cs_up(3*H);

    check("wr_queue_drained", 16'(exp_wr.size()), 16'h0);
    check("rd_queue_drained", 16'(exp_rd.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
